fetch_queue: RTL and testbench

//  Instruction fetch queue between the IF stage and the ID stage of the 5-stage RV32I core.

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 71 +++++++
 tb/tb_fetch_queue.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between IF, the fetch queue and ID: push side, pop side and flush.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                       flush_c_i;
    logic                       push_valid_i;
    logic [31:0]                instruction_i;
    logic [31:0]                pc_i;
    logic [31:0]                pc_next_i;
    logic                       push_ready_o;
    logic                       stall_c_o;
    logic                       pop_valid_o;
    logic                       pop_ready_i;
    logic [31:0]                instruction_o;
    logic [31:0]                pc_o;
    logic [31:0]                pc_next_o;
    logic [$clog2(DEPTH):0]     count_o;

    // The queue itself
    modport slave (
        input  flush_c_i, push_valid_i, instruction_i, pc_i, pc_next_i, pop_ready_i,
        output push_ready_o, stall_c_o, pop_valid_o, instruction_o, pc_o, pc_next_o, count_o
    );

    // The pipeline side driving and consuming the queue
    modport master (
        output flush_c_i, push_valid_i, instruction_i, pc_i, pc_next_i, pop_ready_i,
        input  push_ready_o, stall_c_o, pop_valid_o, instruction_o, pc_o, pc_next_o, count_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Show-ahead circular instruction queue between IF and ID with flush on taken jumps.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [95:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic pushReady;
    logic popValid;
    logic pushFire;
    logic popFire;

    // No pass-through when full: readiness depends only on the registered count.
    assign pushReady = (count_q != CNT_W'(DEPTH));
    assign popValid  = (count_q != '0);
    assign pushFire  = bus.push_valid_i & pushReady & ~bus.flush_c_i;
    assign popFire   = bus.pop_ready_i & popValid & ~bus.flush_c_i;

    assign bus.push_ready_o  = pushReady;
    assign bus.stall_c_o     = ~pushReady;
    assign bus.pop_valid_o   = popValid;
    assign bus.count_o       = count_q;
    assign bus.instruction_o = popValid ? mem_q[rdPtr_q][95:64] : 32'd0;
    assign bus.pc_o          = popValid ? mem_q[rdPtr_q][63:32] : 32'd0;
    assign bus.pc_next_o     = popValid ? mem_q[rdPtr_q][31:0]  : 32'd0;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (bus.flush_c_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushFire) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (popFire)  rdPtr_d = rdPtr_q + PTR_W'(1);
            case ({pushFire, popFire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; entries are only observable once counted.
    always_ff @(posedge clk) begin
        if (pushFire) mem_q[wrPtr_q] <= {bus.instruction_i, bus.pc_i, bus.pc_next_i};
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed table vectors plus randomized traffic checked against a queue-based model.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic        flush;
        logic        pushValid;
        logic [31:0] pc;
        logic        popReady;
        int          expCount;
        logic        expValid;
        logic [31:0] expPc;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [95:0] modelQ [$];
    vec_t vecs [$];

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mkInstr(input logic [31:0] pc);
        return 32'h0000_0013 | (pc << 7);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: a plain FIFO queue; flush empties it, pop uses pre-edge head, push appends if room.
    task automatic applyStimulus(input logic flush, input logic pv, input logic [31:0] pc, input logic pr);
        bus.flush_c_i     = flush;
        bus.push_valid_i  = pv;
        bus.pc_i          = pc;
        bus.pc_next_i     = pc + 32'd4;
        bus.instruction_i = mkInstr(pc);
        bus.pop_ready_i   = pr;
        if (flush) begin
            modelQ.delete();
        end else begin
            int sizeBefore = modelQ.size();
            if (pr && sizeBefore > 0) void'(modelQ.pop_front());
            if (pv && sizeBefore < DEPTH) modelQ.push_back({mkInstr(pc), pc, pc + 32'd4});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        int n = modelQ.size();
        logic [95:0] head = (n > 0) ? modelQ[0] : 96'd0;
        checkOutput({tag, ".count"}, 32'(bus.count_o), 32'(n));
        checkOutput({tag, ".popValid"}, 32'(bus.pop_valid_o), 32'(n > 0));
        checkOutput({tag, ".pushReady"}, 32'(bus.push_ready_o), 32'(n < DEPTH));
        checkOutput({tag, ".stall"}, 32'(bus.stall_c_o), 32'(n >= DEPTH));
        checkOutput({tag, ".instr"}, bus.instruction_o, head[95:64]);
        checkOutput({tag, ".pc"}, bus.pc_o, head[63:32]);
        checkOutput({tag, ".pcNext"}, bus.pc_next_o, head[31:0]);
    endtask

    function automatic vec_t mkVec(input logic fl, input logic pv, input logic [31:0] pc, input logic pr,
                                   input int ec, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.flush = fl; v.pushValid = pv; v.pc = pc; v.popReady = pr;
        v.expCount = ec; v.expValid = ev; v.expPc = ep;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        bus.flush_c_i = 0; bus.push_valid_i = 0; bus.pop_ready_i = 0;
        bus.pc_i = 0; bus.pc_next_i = 0; bus.instruction_i = 0;

        // Fill four, push into full, drain four, pop while empty
        vecs.push_back(mkVec(0, 1, 32'h00, 0, 1, 1, 32'h00));
        vecs.push_back(mkVec(0, 1, 32'h04, 0, 2, 1, 32'h00));
        vecs.push_back(mkVec(0, 1, 32'h08, 0, 3, 1, 32'h00));
        vecs.push_back(mkVec(0, 1, 32'h0C, 0, 4, 1, 32'h00));
        vecs.push_back(mkVec(0, 1, 32'h10, 0, 4, 1, 32'h00));
        vecs.push_back(mkVec(0, 0, 32'h00, 1, 3, 1, 32'h04));
        vecs.push_back(mkVec(0, 0, 32'h00, 1, 2, 1, 32'h08));
        vecs.push_back(mkVec(0, 0, 32'h00, 1, 1, 1, 32'h0C));
        vecs.push_back(mkVec(0, 0, 32'h00, 1, 0, 0, 32'h00));
        vecs.push_back(mkVec(0, 0, 32'h00, 1, 0, 0, 32'h00));
        // Steady push+pop at count 1 across pointer wrap
        vecs.push_back(mkVec(0, 1, 32'h100, 0, 1, 1, 32'h100));
        for (int k = 1; k <= 10; k++)
            vecs.push_back(mkVec(0, 1, 32'h100 + 32'(4 * k), 1, 1, 1, 32'h100 + 32'(4 * k)));
        // Grow to 3, flush with a concurrent push, hold flush, then refill
        vecs.push_back(mkVec(0, 1, 32'h300, 0, 2, 1, 32'h128));
        vecs.push_back(mkVec(0, 1, 32'h304, 0, 3, 1, 32'h128));
        vecs.push_back(mkVec(1, 1, 32'h200, 1, 0, 0, 32'h000));
        vecs.push_back(mkVec(1, 1, 32'h200, 1, 0, 0, 32'h000));
        vecs.push_back(mkVec(0, 1, 32'h200, 0, 1, 1, 32'h200));
        vecs.push_back(mkVec(0, 1, 32'h204, 0, 2, 1, 32'h200));

        rst_n = 1'b0;
        #17;
        checkOutput("reset.count", 32'(bus.count_o), 32'd0);
        checkOutput("reset.popValid", 32'(bus.pop_valid_o), 32'd0);
        checkOutput("reset.pushReady", 32'(bus.push_ready_o), 32'd1);
        checkOutput("reset.stall", 32'(bus.stall_c_o), 32'd0);
        checkOutput("reset.pc", bus.pc_o, 32'd0);
        checkOutput("reset.instr", bus.instruction_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].flush, vecs[i].pushValid, vecs[i].pc, vecs[i].popReady);
            checkOutput($sformatf("vec%0d.count", i), 32'(bus.count_o), 32'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d.popValid", i), 32'(bus.pop_valid_o), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d.pushReady", i), 32'(bus.push_ready_o), 32'(vecs[i].expCount != DEPTH));
            checkOutput($sformatf("vec%0d.pc", i), bus.pc_o, vecs[i].expPc);
            checkOutput($sformatf("vec%0d.pcNext", i), bus.pc_next_o,
                        vecs[i].expValid ? vecs[i].expPc + 32'd4 : 32'd0);
            checkOutput($sformatf("vec%0d.instr", i), bus.instruction_o,
                        vecs[i].expValid ? mkInstr(vecs[i].expPc) : 32'd0);
            checkModel($sformatf("vec%0d.model", i));
        end

        // Asynchronous reset between edges with two entries queued
        applyStimulus(0, 0, 32'h0, 0);
        #3 rst_n = 1'b0;
        #1;
        modelQ.delete();
        checkOutput("asyncRst.count", 32'(bus.count_o), 32'd0);
        checkOutput("asyncRst.popValid", 32'(bus.pop_valid_o), 32'd0);
        checkOutput("asyncRst.pushReady", 32'(bus.push_ready_o), 32'd1);
        checkOutput("asyncRst.stall", 32'(bus.stall_c_o), 32'd0);
        checkOutput("asyncRst.pc", bus.pc_o, 32'd0);
        #2 rst_n = 1'b1;

        for (int c = 0; c < 400; c++) begin
            logic fl = ($urandom_range(0, 15) == 0);
            logic pv = ($urandom_range(0, 3) != 0);
            logic pr = ($urandom_range(0, 2) != 0);
            logic [31:0] pc = {$urandom_range(0, 32'h3FFF), 2'b00};
            applyStimulus(fl, pv, pc, pr);
            checkModel($sformatf("rand%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
